// File: rtl/uart_fifo_ctrl.sv
// Buffered CoreUART controller: TX/RX FIFOs, per-direction strobe FSMs, deferred baud update, RX overrun flag.
// Define UART_OVR_CNT_EN to add the saturating ovr_cnt output counting dropped RX characters.

module uart_fifo_ctrl_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [LW-1:0] level_n;
    logic          push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_n = push_ok ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_n = pop_ok  ? rd_ptr + 1'b1 : rd_ptr;
        level_n  = level;
        if (push_ok && !pop_ok)
            level_n = level + LW'(1);
        else if (pop_ok && !push_ok)
            level_n = level - LW'(1);
    end

    // NOTE: storage has no reset; only pointers and flags define validity, so the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Head is registered from next-state pointers so it is valid the cycle after a push into an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            level  <= level_n;
            full   <= (level_n == LW'(DEPTH));
            empty  <= (level_n == '0);
            head   <= (push_ok && wr_ptr == rd_ptr_n) ? din : mem[rd_ptr_n];
        end
    end
endmodule

module uart_fifo_ctrl #(
    parameter int DATA_W       = 8,
    parameter int TX_DEPTH     = 16,
    parameter int RX_DEPTH     = 16,
    parameter int BAUD_W       = 13,
    parameter int BAUD_DEFAULT = 325,
    parameter int GUARD_CYC    = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tx_wr,
    input  logic [DATA_W-1:0]               tx_din,
    output logic                            tx_full,
    output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level,
    input  logic                            rx_rd,
    output logic [DATA_W-1:0]               rx_dout,
    output logic                            rx_empty,
    output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
    output logic                            rx_ovr,
    input  logic                            ovr_clr,
    input  logic                            baud_we,
    input  logic [BAUD_W-1:0]               baud_din,
    input  logic                            TXrd,
    input  logic                            RXrd,
    input  logic [DATA_W-1:0]               RX,
    output logic [DATA_W-1:0]               TX,
    output logic [BAUD_W-1:0]               BAUD_val,
    output logic                            wen,
`ifdef UART_OVR_CNT_EN
    output logic [7:0]                      ovr_cnt,
`endif
    output logic                            oen
);
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_STROBE, TX_WAIT} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_PUSH, RX_WAIT} rx_state_t;

    tx_state_t         tx_state, tx_next;
    rx_state_t         rx_state, rx_next;
    logic [GW-1:0]     guard_cnt;
    logic              tx_pop, tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push, rx_full, overrun;
    logic [DATA_W-1:0] rx_hold;
    logic              pend_valid, both_idle;
    logic [BAUD_W-1:0] pend_val;

    uart_fifo_ctrl_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_wr), .din(tx_din), .pop(tx_pop),
        .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    uart_fifo_ctrl_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .din(rx_hold), .pop(rx_rd),
        .head(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            TX_IDLE:   if (TXrd && !tx_empty) tx_next = TX_LOAD;
            TX_LOAD: begin
                tx_pop  = 1'b1;
                tx_next = TX_STROBE;
            end
            TX_STROBE: tx_next = TX_WAIT;
            TX_WAIT:   if (!TXrd || guard_cnt == GW'(GUARD_CYC-1)) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: if (RXrd) rx_next = RX_READ;
            RX_READ: rx_next = RX_PUSH;
            RX_PUSH: rx_next = RX_WAIT;
            RX_WAIT: if (!RXrd) rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_push   = (rx_state == RX_PUSH);
        overrun   = rx_push & rx_full & ~rx_rd;
        both_idle = (tx_state == TX_IDLE) && (rx_state == RX_IDLE);
    end

    // Strobes are registered from the next state so they are low exactly while in STROBE/READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            guard_cnt <= '0;
            wen       <= 1'b1;
            TX        <= '0;
        end else begin
            tx_state  <= tx_next;
            guard_cnt <= (tx_state == TX_WAIT) ? guard_cnt + 1'b1 : '0;
            wen       <= (tx_next != TX_STROBE);
            if (tx_state == TX_LOAD)
                TX <= tx_head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            oen      <= 1'b1;
            rx_hold  <= '0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            oen      <= (rx_next != RX_READ);
            if (rx_state == RX_READ)
                rx_hold <= RX;
            if (overrun)
                rx_ovr <= 1'b1;
            else if (ovr_clr)
                rx_ovr <= 1'b0;
        end
    end

`ifdef UART_OVR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovr_cnt <= '0;
        else if (ovr_clr)
            ovr_cnt <= overrun ? 8'd1 : 8'd0;
        else if (overrun && ovr_cnt != 8'hFF)
            ovr_cnt <= ovr_cnt + 8'd1;
    end
`endif

    // Baud changes only land while neither direction is mid-transfer; a newer request replaces a pending one.
    always_ff @(posedge clk) begin
        if (rst) begin
            BAUD_val   <= BAUD_W'(BAUD_DEFAULT);
            pend_val   <= '0;
            pend_valid <= 1'b0;
        end else if (baud_we) begin
            if (both_idle) begin
                BAUD_val   <= baud_din;
                pend_valid <= 1'b0;
            end else begin
                pend_val   <= baud_din;
                pend_valid <= 1'b1;
            end
        end else if (pend_valid && both_idle) begin
            BAUD_val   <= pend_val;
            pend_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed self-checking bench for uart_fifo_ctrl; expected values are hand-derived constants.
`timescale 1ns/1ps

module tb_uart_fifo_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_wr = 1'b0;
    logic [7:0]  tx_din = '0;
    logic        tx_full;
    logic [4:0]  tx_level;
    logic        rx_rd = 1'b0;
    logic [7:0]  rx_dout;
    logic        rx_empty;
    logic [4:0]  rx_level;
    logic        rx_ovr;
    logic        ovr_clr = 1'b0;
    logic        baud_we = 1'b0;
    logic [12:0] baud_din = '0;
    logic        TXrd = 1'b0;
    logic        RXrd = 1'b0;
    logic [7:0]  RX = '0;
    logic [7:0]  TX;
    logic [12:0] BAUD_val;
    logic        wen;
    logic        oen;
`ifdef UART_OVR_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] seen [32];
    int         got;
    int         low_cnt;
    int         first_c;
    int         second_c;
    logic       drop;

    uart_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .tx_wr(tx_wr), .tx_din(tx_din), .tx_full(tx_full), .tx_level(tx_level),
        .rx_rd(rx_rd), .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_level(rx_level),
        .rx_ovr(rx_ovr), .ovr_clr(ovr_clr),
        .baud_we(baud_we), .baud_din(baud_din),
        .TXrd(TXrd), .RXrd(RXrd), .RX(RX), .TX(TX), .BAUD_val(BAUD_val),
        .wen(wen),
`ifdef UART_OVR_CNT_EN
        .ovr_cnt(ovr_cnt),
`endif
        .oen(oen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core model: TXrd drops for the cycle after each wen pulse, otherwise ready.
    task automatic drain_tx(input int cycles);
        got     = 0;
        low_cnt = 0;
        drop    = 1'b0;
        tx_wr   = 1'b0;
        TXrd    = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (!wen) begin
                if (got < 32) seen[got] = TX;
                got++;
                drop = 1'b1;
            end else if (drop) begin
                TXrd = 1'b0;
                drop = 1'b0;
            end else begin
                TXrd = 1'b1;
            end
        end
    endtask

    task automatic rx_event(input logic [7:0] val);
        int n;
        RX   = val;
        RXrd = 1'b1;
        n    = 0;
        do begin
            tick();
            n++;
        end while (oen && n < 10);
        check("rx_oen_strobe", oen, 1'b0);
        RXrd = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_baud",     BAUD_val, 13'd325);
        check("rst_wen",      wen, 1'b1);
        check("rst_oen",      oen, 1'b1);
        check("rst_rx_empty", rx_empty, 1'b1);
        check("rst_tx_level", tx_level, 5'd0);
        check("rst_tx_full",  tx_full, 1'b0);
        check("rst_rx_ovr",   rx_ovr, 1'b0);
        check("rst_tx",       TX, 8'h00);

        // TX burst with latency: pushes on c=0..2, first wen low sampled at c=2
        TXrd    = 1'b1;
        got     = 0;
        low_cnt = 0;
        first_c = -1;
        drop    = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tx_wr  = (c < 3);
            tx_din = 8'h41 + 8'(c);
            tick();
            if (!wen) begin
                if (first_c < 0) first_c = c;
                if (got < 32) seen[got] = TX;
                got++;
                drop = 1'b1;
            end else if (drop) begin
                TXrd = 1'b0;
                drop = 1'b0;
            end else begin
                TXrd = 1'b1;
            end
        end
        tx_wr = 1'b0;
        TXrd  = 1'b0;
        check("burst_pulses",  got, 3);
        check("burst_latency", first_c, 2);
        check("burst_tx0",     seen[0], 8'h41);
        check("burst_tx1",     seen[1], 8'h42);
        check("burst_tx2",     seen[2], 8'h43);
        check("burst_tx_hold", TX, 8'h43);
        tick();
        tick();

        // TX full: 17 pushes with TXrd low, 0x60 dropped
        for (int i = 0; i < 17; i++) begin
            tx_wr  = 1'b1;
            tx_din = 8'h50 + 8'(i);
            tick();
        end
        tx_wr = 1'b0;
        check("full_flag",  tx_full, 1'b1);
        check("full_level", tx_level, 5'd16);
        // Push exactly in the LOAD cycle so it coincides with the pop
        TXrd = 1'b1;
        tick();
        TXrd   = 1'b0;
        tx_wr  = 1'b1;
        tx_din = 8'h7E;
        tick();
        tx_wr = 1'b0;
        check("full_pushpop_level", tx_level, 5'd16);
        check("full_pushpop_flag",  tx_full, 1'b1);
        check("full_pushpop_wen",   wen, 1'b0);
        check("full_pushpop_tx",    TX, 8'h50);
        drain_tx(150);
        TXrd = 1'b0;
        tick();
        check("drain_count", got, 16);
        check("drain_first", seen[0], 8'h51);
        check("drain_15",    seen[14], 8'h5F);
        check("drain_last",  seen[15], 8'h7E);
        check("drain_level", tx_level, 5'd0);
        check("drain_full",  tx_full, 1'b0);

        // RX overrun
        for (int i = 0; i < 16; i++) rx_event(8'h10 + 8'(i));
        check("rx_full_level_pre", rx_level, 5'd16);
        check("rx_ovr_pre",        rx_ovr, 1'b0);
        rx_event(8'h20);
        check("rx_ovr_level", rx_level, 5'd16);
        check("rx_ovr_flag",  rx_ovr, 1'b1);
        check("rx_ovr_head",  rx_dout, 8'h10);
        check("rx_ovr_empty", rx_empty, 1'b0);
`ifdef UART_OVR_CNT_EN
        check("ovr_cnt_one", ovr_cnt, 8'd1);
`endif
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("rx_ovr_clr", rx_ovr, 1'b0);
`ifdef UART_OVR_CNT_EN
        check("ovr_cnt_clr", ovr_cnt, 8'd0);
`endif
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
        check("rx_pop_head",  rx_dout, 8'h11);
        check("rx_pop_level", rx_level, 5'd15);
        rx_rd = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        rx_rd = 1'b0;
        check("rx_underflow_level", rx_level, 5'd0);
        check("rx_underflow_empty", rx_empty, 1'b1);

        // Baud deferred while TX is in WAIT
        TXrd   = 1'b1;
        tx_wr  = 1'b1;
        tx_din = 8'h99;
        tick();
        tx_wr = 1'b0;
        tick();
        tick();
        check("defer_wen", wen, 1'b0);
        tick();
        baud_we  = 1'b1;
        baud_din = 13'd162;
        tick();
        baud_we = 1'b0;
        check("defer_hold0", BAUD_val, 13'd325);
        tick();
        check("defer_hold1", BAUD_val, 13'd325);
        TXrd = 1'b0;
        tick();
        check("defer_hold2", BAUD_val, 13'd325);
        tick();
        check("defer_apply", BAUD_val, 13'd162);

        // Immediate apply when both FSMs are idle
        baud_we  = 1'b1;
        baud_din = 13'd200;
        tick();
        baud_we = 1'b0;
        check("baud_immediate", BAUD_val, 13'd200);

        // Guard timeout with TXrd held high; pending baud overwritten during WAIT
        TXrd   = 1'b1;
        tx_wr  = 1'b1;
        tx_din = 8'hA1;
        tick();
        tx_din = 8'hA2;
        tick();
        tx_wr    = 1'b0;
        got      = 0;
        first_c  = -1;
        second_c = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!wen) begin
                if (first_c < 0) first_c = c;
                else if (second_c < 0) second_c = c;
                got++;
            end
            if (c == 2) begin
                baud_we  = 1'b1;
                baud_din = 13'd100;
            end
            if (c == 3) baud_din = 13'd50;
            if (c == 4) begin
                baud_we = 1'b0;
                check("guard_baud_hold", BAUD_val, 13'd200);
            end
        end
        check("guard_pulses",  got, 2);
        check("guard_spacing", second_c - first_c, 4 + 3);
        check("guard_tx",      TX, 8'hA2);
        check("baud_overwrite", BAUD_val, 13'd50);

        // Reset mid-strobe discards FIFO contents and releases wen
        tx_wr  = 1'b1;
        tx_din = 8'hC1;
        tick();
        tx_din = 8'hC2;
        tick();
        tx_wr = 1'b0;
        tick();
        check("midrst_wen_low", wen, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_wen",   wen, 1'b1);
        check("midrst_oen",   oen, 1'b1);
        check("midrst_level", tx_level, 5'd0);
        check("midrst_baud",  BAUD_val, 13'd325);
        TXrd = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
